updown_sequencer: RTL and testbench



---
 rtl/updown_pkg.sv | 14 +
 rtl/updown_sequencer_if.sv | 13 +
 rtl/step_counter.sv | 35 +++
 rtl/updown_sequencer.sv | 80 ++++++++
 tb/tb_updown_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/updown_pkg.sv
// Shared types for the up/down step sequencer: FSM state encoding and
// direction constants used by the sequencer, the counter and the bench.
package updown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_sequencer_if.sv
// Command handshake bundle: the controller (master) offers a direction and a
// step budget; the sequencer (slave) answers with ready while idle.
interface updown_sequencer_if #(
    parameter int STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;

    modport master (output cmd_valid, cmd_dir, cmd_steps, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_steps, output cmd_ready);
endinterface

// File: rtl/step_counter.sv
// WIDTH-bit up/down register; one step per enabled clock, wrapping modulo
// 2^WIDTH in both directions.
module step_counter
    import updown_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sequencer.sv
// Accepts "count N steps up/down" commands and walks the step counter one
// step per clock, with hold/abort control and a one-cycle done pulse.
module updown_sequencer
    import updown_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int STEP_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    updown_sequencer_if.slave   cmd,
    input  logic                hold,
    input  logic                abort,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic              dir_q, dir_d;
    logic              step_en;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        step_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d       = cmd.cmd_dir;
                    remaining_d = cmd.cmd_steps;
                    state_d     = (cmd.cmd_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // abort outranks hold, which outranks stepping
                if (abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (!hold) begin
                    step_en     = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == STEP_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= DIR_UP;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    step_counter #(.WIDTH(WIDTH)) u_step_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (step_en),
        .dir     (dir_q),
        .count   (count)
    );

    // all status outputs decode registered state only
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_updown_sequencer.sv
// Directed bench: stimulus pushes expected counts and done values into
// queues; a monitor pops and compares on every count change and done pulse.
module tb_updown_sequencer;
    import updown_pkg::*;

    localparam int WIDTH  = 2;
    localparam int STEP_W = 4;
    localparam int MOD    = 1 << WIDTH;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             hold    = 1'b0;
    logic             abort   = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    updown_sequencer_if #(.STEP_W(STEP_W)) cmd_if ();

    updown_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cmd     (cmd_if.slave),
        .hold    (hold),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    int  n_vec = 0;
    int  n_err = 0;
    int  exp_cnt_q[$];
    int  exp_done_q[$];
    int  model_cnt = 0;
    int  prev_cnt  = 0;
    time last_acc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: every count change must match the next queued step value,
    // every done pulse must match the queued final count
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                prev_cnt = int'(count);
                continue;
            end
            if (int'(count) != prev_cnt) begin
                if (exp_cnt_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL count_unexpected: got %0d, expected no change from %0d", count, prev_cnt);
                end else begin
                    chk("count_step", int'(count), exp_cnt_q.pop_front());
                end
                prev_cnt = int'(count);
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done_unexpected: got done with count %0d, expected no done", count);
                end else begin
                    chk("done_count", int'(count), exp_done_q.pop_front());
                end
            end
        end
    end

    task automatic run_cmd(input bit dir, input int steps, input int hold_at, input int hold_len,
                           input int abort_at, input bit keep_valid, input int exp_gap);
        int done_steps = 0;
        int held       = 0;
        int edges      = 0;
        int n_exec;
        int exp_lat;
        bit busy_seen  = 1'b0;
        logic [STEP_W-1:0] steps_v;

        n_exec = (abort_at >= 0) ? abort_at : steps;
        for (int i = 0; i < n_exec; i++) begin
            model_cnt = dir ? (model_cnt + 1) % MOD : (model_cnt + MOD - 1) % MOD;
            exp_cnt_q.push_back(model_cnt);
        end
        if (abort_at < 0) exp_done_q.push_back(model_cnt);

        if (abort_at >= 0)
            exp_lat = abort_at + 1 + ((hold_at >= 0 && hold_at < abort_at) ? hold_len : 0);
        else
            exp_lat = steps + 1 + ((hold_at >= 0 && steps > 0) ? hold_len : 0);

        steps_v = steps[STEP_W-1:0];
        @(negedge clock);
        chk("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = steps_v;
        @(posedge clock);
        if (exp_gap > 0) chk("cmd_gap_edges", int'(($time - last_acc) / 10), exp_gap);
        last_acc = $time;
        #1;
        if (keep_valid) begin
            cmd_if.cmd_steps = '1;
            cmd_if.cmd_dir   = ~dir;
        end else begin
            cmd_if.cmd_valid = 1'b0;
        end

        while (!cmd_if.cmd_ready && edges < 40) begin
            @(negedge clock);
            abort = (abort_at >= 0 && done_steps == abort_at);
            hold  = (hold_at >= 0 && done_steps == hold_at && held < hold_len);
            if (busy) busy_seen = 1'b1;
            @(posedge clock);
            #1;
            edges++;
            if (abort) ;
            else if (hold) held++;
            else if (done_steps < steps) done_steps++;
            hold  = 1'b0;
            abort = 1'b0;
        end
        chk("cmd_to_ready_edges", edges, exp_lat);
        chk("busy_during_cmd", int'(busy_seen), (steps > 0) ? 1 : 0);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = DIR_DOWN;
        cmd_if.cmd_steps = '0;

        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_cmd(1'b1, 5, -1, 0, -1, 1'b0, 0);   // up wrap: 1,2,3,0,1
        run_cmd(1'b0, 3, -1, 0, -1, 1'b0, 0);   // down wrap: 0,3,2
        run_cmd(1'b1, 0, -1, 0, -1, 1'b0, 0);   // zero steps
        run_cmd(1'b1, 4, 1, 2, -1, 1'b0, 0);    // hold 2 cycles after step 1
        run_cmd(1'b1, 4, 2, 1, 2, 1'b0, 0);     // abort+hold after step 2

        // valid held high with junk fields mid-command; back-to-back spacing N+2
        run_cmd(1'b1, 3, -1, 0, -1, 1'b1, 0);
        run_cmd(1'b0, 2, -1, 0, -1, 1'b1, 5);
        run_cmd(1'b1, 1, -1, 0, -1, 1'b0, 4);
        chk("final_count_handshake", int'(count), 2);

        // reset in the middle of a 5-step command
        exp_cnt_q.push_back((model_cnt + 1) % MOD);
        exp_cnt_q.push_back((model_cnt + 2) % MOD);
        @(negedge clock);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = DIR_UP;
        cmd_if.cmd_steps = 4'd5;
        @(posedge clock);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrun_rst_count", int'(count), 0);
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_done", int'(done), 0);
        chk("midrun_rst_ready", int'(cmd_if.cmd_ready), 1);
        model_cnt = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_count", int'(count), 0);
        repeat (3) @(posedge clock);
        #1;

        chk("count_queue_drained", exp_cnt_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
